// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline front end.
// Trap vectors, reset PC, nop encoding, kernel-bit index.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          KBIT      = 31;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM port, redirect/hazard inputs,
// IF/ID register outputs and EPC write port.
interface if_stage_if;

    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic        stall;
    logic        jmp_taken;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc;
    logic        irq;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;
    logic        epc_we;

    modport master (
        output rom_addr,
        input  rom_instr,
        input  stall,
        input  jmp_taken,
        input  jmp_target,
        input  br_taken,
        input  br_target,
        input  exc,
        input  irq,
        output if_id_instr,
        output if_id_pc_plus4,
        output if_id_valid,
        output epc,
        output epc_we
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        output stall,
        output jmp_taken,
        output jmp_target,
        output br_taken,
        output br_target,
        output exc,
        output irq,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  if_id_valid,
        input  epc,
        input  epc_we
    );

endinterface

// File: rtl/if_stage_irq_sync.sv
// Two-flop synchronizer for the asynchronous timer irq.
// Used only when IF_IRQ_SYNC_EN is defined.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both flops clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC select, IF/ID register, EPC.
// Optional irq synchronizer: define IF_IRQ_SYNC_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] IRQ_VEC  = mips_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = mips_pkg::EXC_VEC
) (
    input logic        clk,
    input logic        reset,
    if_stage_if.master bus
);

    import mips_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] trap_ret;
    logic        irq_q;
    logic        irq_take;
    logic        flush;

`ifdef IF_IRQ_SYNC_EN
    irq_sync u_irq_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (bus.irq),
        .q     (irq_q)
    );
`else
    assign irq_q = bus.irq;
`endif

    assign pc_plus4 = {pc[KBIT], pc[30:0] + 31'd4};

    assign irq_take = irq_q & ~pc[KBIT]
                    & ~bus.stall & ~bus.exc;

    assign flush = bus.exc | irq_take
                 | bus.br_taken | bus.jmp_taken;

    assign bus.rom_addr = pc;

    // Next PC by redirect priority; stall only holds.
    always_comb begin
        pc_next = pc_plus4;
        priority case (1'b1)
            bus.exc:       pc_next = EXC_VEC;
            irq_take:      pc_next = IRQ_VEC;
            bus.br_taken:  pc_next = bus.br_target;
            bus.jmp_taken: pc_next = bus.jmp_target;
            bus.stall:     pc_next = pc;
            default:       pc_next = pc_plus4;
        endcase
    end

    // Interrupt resumes where fetch would have gone.
    always_comb begin
        trap_ret = pc;
        priority case (1'b1)
            bus.br_taken:  trap_ret = bus.br_target;
            bus.jmp_taken: trap_ret = bus.jmp_target;
            default:       trap_ret = pc;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else        pc <= pc_next;
    end

    // IF/ID register: bubble on redirect, hold on stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.if_id_instr    <= NOP_INSTR;
            bus.if_id_pc_plus4 <= 32'h0;
            bus.if_id_valid    <= 1'b0;
        end else if (flush) begin
            bus.if_id_instr    <= NOP_INSTR;
            bus.if_id_pc_plus4 <= 32'h0;
            bus.if_id_valid    <= 1'b0;
        end else if (!bus.stall) begin
            bus.if_id_instr    <= bus.rom_instr;
            bus.if_id_pc_plus4 <= pc_plus4;
            bus.if_id_valid    <= 1'b1;
        end
    end

    // EPC capture with a one-cycle write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.epc    <= 32'h0;
            bus.epc_we <= 1'b0;
        end else if (bus.exc) begin
            bus.epc    <= bus.if_id_pc_plus4;
            bus.epc_we <= 1'b1;
        end else if (irq_take) begin
            bus.epc    <= trap_ret;
            bus.epc_we <= 1'b1;
        end else begin
            bus.epc_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage.
// ROM model returns the bitwise inverse of the address.
module tb_if_stage;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rom_instr = ~bus.rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        exc;
        logic        irq;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
        logic        e_val;
        logic        e_we;
        logic [31:0] e_epc;
    } vec_t;

    vec_t v [28];

    function automatic vec_t mk(
        input logic        stall,
        input logic        jmp,
        input logic [31:0] jt,
        input logic        br,
        input logic [31:0] bt,
        input logic        exc,
        input logic        irq,
        input logic [31:0] e_pc,
        input logic [31:0] e_ins,
        input logic [31:0] e_pc4,
        input logic        e_val,
        input logic        e_we,
        input logic [31:0] e_epc
    );
        vec_t r;
        r.stall = stall; r.jmp = jmp; r.jt = jt;
        r.br = br; r.bt = bt; r.exc = exc; r.irq = irq;
        r.e_pc = e_pc; r.e_ins = e_ins; r.e_pc4 = e_pc4;
        r.e_val = e_val; r.e_we = e_we; r.e_epc = e_epc;
        return r;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(
        input string       tag,
        input logic [31:0] e_pc,
        input logic [31:0] e_ins,
        input logic [31:0] e_pc4,
        input logic        e_val,
        input logic        e_we,
        input logic [31:0] e_epc
    );
        chk({tag, " rom_addr"}, bus.rom_addr, e_pc);
        chk({tag, " instr"}, bus.if_id_instr, e_ins);
        chk({tag, " pc4"}, bus.if_id_pc_plus4, e_pc4);
        chk({tag, " valid"}, 32'(bus.if_id_valid), 32'(e_val));
        chk({tag, " epc_we"}, 32'(bus.epc_we), 32'(e_we));
        chk({tag, " epc"}, bus.epc, e_epc);
    endtask

    task automatic drive(input vec_t x);
        bus.stall      = x.stall;
        bus.jmp_taken  = x.jmp;
        bus.jmp_target = x.jt;
        bus.br_taken   = x.br;
        bus.br_target  = x.bt;
        bus.exc        = x.exc;
        bus.irq        = x.irq;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // stall jmp jt br bt exc irq | pc ins pc4 val we epc
        v[0]  = mk(0,0,0,0,0,0,0, 32'h80000004,32'h7FFFFFFF,
                   32'h80000004,1,0,32'h0);
        v[1]  = mk(0,0,0,0,0,0,0, 32'h80000008,32'h7FFFFFFB,
                   32'h80000008,1,0,32'h0);
        v[2]  = mk(0,0,0,0,0,0,0, 32'h8000000C,32'h7FFFFFF7,
                   32'h8000000C,1,0,32'h0);
        v[3]  = mk(0,0,0,0,0,0,0, 32'h80000010,32'h7FFFFFF3,
                   32'h80000010,1,0,32'h0);
        v[4]  = mk(0,1,32'h1C,0,0,0,0, 32'h0000001C,32'h0,
                   32'h0,0,0,32'h0);
        v[5]  = mk(0,0,0,0,0,0,0, 32'h00000020,32'hFFFFFFE3,
                   32'h00000020,1,0,32'h0);
        v[6]  = mk(0,1,32'h3C,0,0,0,0, 32'h0000003C,32'h0,
                   32'h0,0,0,32'h0);
        v[7]  = mk(0,0,0,0,0,0,0, 32'h00000040,32'hFFFFFFC3,
                   32'h00000040,1,0,32'h0);
        v[8]  = mk(1,0,0,0,0,0,0, 32'h00000040,32'hFFFFFFC3,
                   32'h00000040,1,0,32'h0);
        v[9]  = mk(1,0,0,0,0,0,0, 32'h00000040,32'hFFFFFFC3,
                   32'h00000040,1,0,32'h0);
        v[10] = mk(0,0,0,0,0,0,0, 32'h00000044,32'hFFFFFFBF,
                   32'h00000044,1,0,32'h0);
        v[11] = mk(1,0,0,1,32'h130,0,0, 32'h00000130,32'h0,
                   32'h0,0,0,32'h0);
        v[12] = mk(0,0,0,0,0,0,0, 32'h00000134,32'hFFFFFECF,
                   32'h00000134,1,0,32'h0);
        v[13] = mk(0,0,0,0,0,0,1, 32'h80000004,32'h0,
                   32'h0,0,1,32'h134);
        v[14] = mk(0,0,0,0,0,0,0, 32'h80000008,32'h7FFFFFFB,
                   32'h80000008,1,0,32'h134);
        v[15] = mk(0,1,32'h80000170,0,0,0,0, 32'h80000170,32'h0,
                   32'h0,0,0,32'h134);
        v[16] = mk(0,0,0,0,0,0,1, 32'h80000174,32'h7FFFFE8F,
                   32'h80000174,1,0,32'h134);
        v[17] = mk(0,1,32'h200,0,0,0,1, 32'h00000200,32'h0,
                   32'h0,0,0,32'h134);
        v[18] = mk(0,0,0,1,32'h300,0,1, 32'h80000004,32'h0,
                   32'h0,0,1,32'h300);
        v[19] = mk(0,0,0,0,0,0,0, 32'h80000008,32'h7FFFFFFB,
                   32'h80000008,1,0,32'h300);
        v[20] = mk(0,0,0,0,0,0,0, 32'h8000000C,32'h7FFFFFF7,
                   32'h8000000C,1,0,32'h300);
        v[21] = mk(0,0,0,1,32'h500,1,1, 32'h80000008,32'h0,
                   32'h0,0,1,32'h8000000C);
        v[22] = mk(0,0,0,0,0,0,0, 32'h8000000C,32'h7FFFFFF7,
                   32'h8000000C,1,0,32'h8000000C);
        v[23] = mk(0,1,32'h7FFFFFFC,0,0,0,0, 32'h7FFFFFFC,32'h0,
                   32'h0,0,0,32'h8000000C);
        v[24] = mk(0,0,0,0,0,0,0, 32'h00000000,32'h80000003,
                   32'h00000000,1,0,32'h8000000C);
        v[25] = mk(1,0,0,0,0,0,1, 32'h00000000,32'h80000003,
                   32'h00000000,1,0,32'h8000000C);
        v[26] = mk(0,1,32'h20,0,0,0,1, 32'h80000004,32'h0,
                   32'h0,0,1,32'h20);
        v[27] = mk(0,0,0,0,0,0,0, 32'h80000008,32'h7FFFFFFB,
                   32'h80000008,1,0,32'h20);

        reset = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h80000000, 32'h0, 32'h0, 0, 0, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 28; i++) begin
            drive(v[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), v[i].e_pc, v[i].e_ins,
                    v[i].e_pc4, v[i].e_val, v[i].e_we, v[i].e_epc);
            @(negedge clk);
        end

        // Reset asserted mid-cycle while stalled.
        drive(mk(1,0,0,0,0,0,1,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk_all("stall_pre", 32'h80000008, 32'h7FFFFFFB,
                32'h80000008, 1, 0, 32'h20);
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst_mid", 32'h80000000, 32'h0, 32'h0, 0, 0, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk_all("rst_rel", 32'h80000004, 32'h7FFFFFFF,
                32'h80000004, 1, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
